// File: rtl/gcd_sched.sv
// gcd_sched: round-robin scheduler that shares one GCD core between N
// requesters. A job whose operands include a zero skips the core. A job
// that overstays its cycle budget in BUSY is aborted and returned with
// rsp_err set.
module gcd_sched #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   op_a,
  input  logic [N*W-1:0]   op_b,
  output logic [N-1:0]     gnt,
  output logic             gcd_start,
  output logic             gcd_abort,
  output logic [W-1:0]     gcd_a,
  output logic [W-1:0]     gcd_b,
  input  logic             gcd_done,
  input  logic [W-1:0]     gcd_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, BUSY, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr, idx, win, cand;
  logic           found;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_sel, b_sel;
  logic           req_idx;

  // Round-robin pick: first set request at or above rr, wrapping modulo N.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(rr) + k) % N);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Operand mux for the registered winner, plus the grant for that slot.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    req_idx = 1'b0;
    gnt     = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDW'(i)) begin
        a_sel   = op_a[i*W +: W];
        b_sel   = op_b[i*W +: W];
        req_idx = req[i];
        gnt[i]  = (state == GRANT) && req[i];
      end
    end
  end

  assign rsp_valid = (state == RESP);

  // Next-state logic and the one-cycle core control pulses.
  always_comb begin
    state_nxt = state;
    gcd_start = 1'b0;
    gcd_abort = 1'b0;
    case (state)
      IDLE:   if (|req) state_nxt = GRANT;
      GRANT: begin
        if (!req_idx)                        state_nxt = IDLE;   // withdrawn
        else if (a_sel == '0 || b_sel == '0) state_nxt = RESP;   // bypass
        else                                 state_nxt = LAUNCH;
      end
      LAUNCH: begin
        gcd_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        // done has priority over a timeout landing in the same cycle
        if (gcd_done) state_nxt = RESP;
        else if (cnt == CNT_MAX) begin
          gcd_abort = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, watchdog counter and the captured job/response fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr         <= '0;
      idx        <= '0;
      cnt        <= '0;
      gcd_a      <= '0;
      gcd_b      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req) idx <= win;
        GRANT: if (req_idx) begin
          gcd_a      <= a_sel;
          gcd_b      <= b_sel;
          rsp_id     <= idx;
          rsp_result <= a_sel | b_sel;   // bypass answer; replaced by core result otherwise
          rsp_err    <= 1'b0;
        end
        LAUNCH: cnt <= '0;
        BUSY: begin
          if (gcd_done) begin
            rsp_result <= gcd_result;
            rsp_err    <= 1'b0;
          end else if (cnt == CNT_MAX) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (rsp_ready) rr <= (idx == IDW'(N - 1)) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a queue scoreboard. The stimulus thread
// pushes the expected grants and responses; a monitor pops and compares them.
module tb_gcd_sched;
  localparam int N = 4, W = 8, IDW = 2, TO = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   op_a = '0, op_b = '0;
  logic [N-1:0]     gnt;
  logic             gcd_start, gcd_abort;
  logic [W-1:0]     gcd_a, gcd_b;
  logic             gcd_done = 1'b0;
  logic [W-1:0]     gcd_result = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_err;

  gcd_sched #(.N(N), .W(W), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .gcd_start(gcd_start), .gcd_abort(gcd_abort), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_result(gcd_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0, n_start = 0;
  logic [N-1:0] gnt_q[$];
  logic [10:0]  rsp_q[$];
  int core_delay = -1;       // BUSY cycles until done; -1 = never
  logic [W-1:0] core_res = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] pk(input int id, input int r, input bit e);
    return {2'(id), 8'(r), e};
  endfunction

  // Core stand-in: done with the preset result core_delay cycles after start.
  initial forever begin
    @(negedge clk);
    if (gcd_start && core_delay > 0) begin
      repeat (core_delay) @(posedge clk);
      #1 gcd_done = 1'b1; gcd_result = core_res;
      @(posedge clk);
      #1 gcd_done = 1'b0; gcd_result = '0;
    end
  end

  // Monitor: grants, pulse exclusivity, payload hold under stall, responses.
  bit held = 0;
  logic [10:0] held_val;
  initial forever begin
    @(negedge clk);
    if (!rst) held = 0;
    else begin
      if (gcd_start) n_start++;
      if (gnt != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'(0));
        else chk("gnt", 64'(gnt), 64'(gnt_q.pop_front()));
      end
      if (gnt != '0 || gcd_start || gcd_abort)
        chk("pulse_excl", 64'($countones(gnt)) + 64'(gcd_start) + 64'(gcd_abort), 64'(1));
      if (rsp_valid) begin
        if (held) chk("rsp_hold", 64'({rsp_id, rsp_result, rsp_err}), 64'(held_val));
        if (rsp_ready) begin
          held = 0;
          if (rsp_q.size() == 0) chk("rsp_unexpected", 64'({rsp_id, rsp_result, rsp_err}), 64'(0));
          else chk("rsp", 64'({rsp_id, rsp_result, rsp_err}), 64'(rsp_q.pop_front()));
        end else begin
          held = 1;
          held_val = {rsp_id, rsp_result, rsp_err};
        end
      end else held = 0;
    end
  end

  // Bounded wait at negedges: 0 gnt, 1 start, 2 abort, 3 rsp_valid, 4 !rsp_valid.
  task automatic wait_for(input int which, output int c);
    bit hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk);
      case (which)
        0: hit = (gnt != '0);
        1: hit = gcd_start;
        2: hit = gcd_abort;
        3: hit = rsp_valid;
        default: hit = !rsp_valid;
      endcase
    end
    c = cyc;
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_%0d: got timeout expected event", which);
    end
  endtask

  task automatic set_slot(input int s, input int a, input int b);
    op_a[s*W +: W] = 8'(a);
    op_b[s*W +: W] = 8'(b);
  endtask

  task automatic drop(input int s);
    @(posedge clk); #1 req[s] = 1'b0;
  endtask

  // One job on slot s, dropping req after its grant; returns grant/valid cycles.
  task automatic job(input int s, input int a, input int b, output int g, output int v);
    int d;
    set_slot(s, a, b);
    @(posedge clk); #1 req[s] = 1'b1;
    wait_for(0, g);
    drop(s);
    wait_for(3, v);
    if (rsp_ready) wait_for(4, d);
  endtask

  int g, s, v, a, h, n0, d;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'({gnt, gcd_start, gcd_abort, gcd_a, gcd_b, rsp_valid,
                           rsp_id, rsp_result, rsp_err}), 64'(0));
    rst = 1'b1;

    // round-robin with all four held; bypass operands keep it quick
    for (int i = 0; i < N; i++) set_slot(i, 0, i + 1);
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    rsp_q.push_back(pk(0, 1, 0)); rsp_q.push_back(pk(1, 2, 0)); rsp_q.push_back(pk(2, 3, 0));
    rsp_q.push_back(pk(3, 4, 0)); rsp_q.push_back(pk(0, 1, 0));
    @(posedge clk); #1 req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_for(0, g);
    @(posedge clk); #1 req = '0;
    wait_for(4, d);

    // single job 12,18 -> 6 through the core
    core_delay = 5; core_res = 8'd6; n0 = n_start;
    gnt_q.push_back(4'b0001); rsp_q.push_back(pk(0, 6, 0));
    set_slot(0, 12, 18);
    @(posedge clk); #1 req[0] = 1'b1;
    wait_for(0, g);
    drop(0);
    wait_for(1, s);
    chk("start_lat", 64'(s - g), 64'(1));
    chk("gcd_ab", 64'({gcd_a, gcd_b}), 64'({8'd12, 8'd18}));
    wait_for(3, v);
    chk("done_lat", 64'(v - s), 64'(6));
    wait_for(4, d);
    chk("start_count", 64'(n_start - n0), 64'(1));

    // zero bypass: no core start, response one cycle after grant
    n0 = n_start;
    gnt_q.push_back(4'b0100); rsp_q.push_back(pk(2, 35, 0));
    job(2, 0, 35, g, v);
    chk("bypass_lat", 64'(v - g), 64'(1));
    gnt_q.push_back(4'b0100); rsp_q.push_back(pk(2, 0, 0));
    job(2, 0, 0, g, v);
    gnt_q.push_back(4'b1000); rsp_q.push_back(pk(3, 20, 0));
    job(3, 20, 0, g, v);
    chk("bypass_nostart", 64'(n_start - n0), 64'(0));

    // backpressure: 10-cycle stall, competing request must wait
    rsp_ready = 1'b0; core_delay = 3; core_res = 8'd7;
    gnt_q.push_back(4'b0010); rsp_q.push_back(pk(1, 7, 0));
    set_slot(1, 21, 14);
    @(posedge clk); #1 req[1] = 1'b1;
    wait_for(0, g);
    drop(1);
    wait_for(3, v);
    set_slot(3, 0, 5);
    @(posedge clk); #1 req[3] = 1'b1;
    repeat (10) @(posedge clk);
    gnt_q.push_back(4'b1000); rsp_q.push_back(pk(3, 5, 0));
    #1 rsp_ready = 1'b1; h = cyc;
    wait_for(0, g);
    chk("post_stall_gnt", 64'(g - h), 64'(2));
    drop(3);
    wait_for(4, d);

    // watchdog: core never finishes
    core_delay = -1;
    gnt_q.push_back(4'b0001); rsp_q.push_back(pk(0, 0, 1));
    set_slot(0, 9, 6);
    @(posedge clk); #1 req[0] = 1'b1;
    wait_for(0, g);
    drop(0);
    wait_for(2, a);
    chk("abort_lat", 64'(a - g), 64'(TO + 1));
    @(negedge clk);
    chk("abort_width", 64'(gcd_abort), 64'(0));
    chk("timeout_valid", 64'(rsp_valid), 64'(1));
    chk("timeout_lat", 64'(cyc - g), 64'(TO + 2));
    wait_for(4, d);
    core_delay = 2; core_res = 8'd3;
    gnt_q.push_back(4'b0001); rsp_q.push_back(pk(0, 3, 0));
    job(0, 9, 6, g, v);

    // asynchronous reset while BUSY: response is lost
    core_delay = -1;
    gnt_q.push_back(4'b0100);
    set_slot(2, 4, 6);
    @(posedge clk); #1 req[2] = 1'b1;
    wait_for(0, g);
    drop(2);
    wait_for(1, s);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("midjob_reset", 64'({gnt, gcd_start, gcd_abort, gcd_a, gcd_b, rsp_valid,
                                rsp_id, rsp_result, rsp_err}), 64'(0));
    @(negedge clk); rst = 1'b1;
    gnt_q.push_back(4'b0010); rsp_q.push_back(pk(1, 9, 0));
    job(1, 0, 9, g, v);

    repeat (5) @(negedge clk);
    chk("gnt_q_left", 64'(gnt_q.size()), 64'(0));
    chk("rsp_q_left", 64'(rsp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gcd_sched.md
Name: gcd_sched

Overview:
Scheduler that shares one GCD core (controller plus datapath) between N requesters. It arbitrates requests round-robin and captures the winner's operands. It launches the core with a start pulse, waits for done, and returns the result tagged with the requester ID over a valid/ready response channel. A zero-operand bypass and a watchdog timeout ensure the core is never started on, or stuck with, a non-terminating job.

Parameters:
N, 4, number of requesters (2..16)
W, 8, operand/result width in bits
IDW, 2, requester ID width; must equal clog2(N)
TIMEOUT, 1024, maximum cycles allowed in BUSY before abort (>=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
req  in  N  per-requester request; held until its gnt bit is seen
op_a  in  N*W  operand A; slot i occupies bits [i*W +: W]
op_b  in  N*W  operand B; same packing as op_a
gnt  out  N  one-hot one-cycle grant; operands of that slot are captured on this cycle
gcd_start  out  1  one-cycle start pulse to the GCD core
gcd_abort  out  1  one-cycle abort pulse to the GCD core on timeout
gcd_a  out  W  captured operand A, stable from LAUNCH through BUSY
gcd_b  out  W  captured operand B, stable from LAUNCH through BUSY
gcd_done  in  1  core completion, sampled only in BUSY
gcd_result  in  W  core result, valid when gcd_done=1
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer ready
rsp_id  out  IDW  requester index of the response
rsp_result  out  W  GCD result
rsp_err  out  1  1 = job aborted by timeout; rsp_result = 0

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; rr pointer = 0; cycle counter = 0.
  - All outputs 0, including gcd_a, gcd_b, rsp_id, rsp_result and rsp_err.
- States: IDLE, GRANT, LAUNCH, BUSY, RESP.
- IDLE:
  - If req != 0, register winner idx = first set bit scanning upward from the rr pointer, wrapping modulo N. Go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If req[idx]=1: assert gnt[idx]=1 for exactly this cycle, capture op_a/op_b slot idx into gcd_a/gcd_b, and set rsp_id=idx.
  - If either captured operand is 0: go to RESP with rsp_result = a|b (gcd(0,x)=x, gcd(0,0)=0) and rsp_err=0. The core is not started.
  - Otherwise go to LAUNCH.
  - If req[idx]=0 (request withdrawn): no grant; return to IDLE with the pointer unchanged.
- LAUNCH: gcd_start=1 for one cycle; counter cleared; go to BUSY.
- BUSY:
  - On gcd_done=1: capture gcd_result into rsp_result, set rsp_err=0, go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT-1 without done: gcd_abort=1 for one cycle, rsp_result=0, rsp_err=1, go to RESP.
  - If done and timeout fall in the same cycle, done wins.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_result and rsp_err held stable until rsp_ready=1.
  - On the handshake cycle (valid & ready): go to IDLE and set rr pointer = (idx+1) mod N.
  - rsp_valid deasserts the following cycle.
- Only one job is in flight at a time. req is not sampled outside IDLE and GRANT.
- Latency:
  - req seen in IDLE at cycle t gives gnt at t+1.
  - Bypass: rsp_valid at t+2.
  - Normal: gcd_start at t+2. If done is seen at BUSY cycle u, rsp_valid is at u+1.
  - Timeout: rsp_valid at t+3+TIMEOUT.
- Fairness: a continuously requesting slot is granted within N jobs.
- Reset mid-job: immediate return to IDLE. A response never delivered is lost; the requester must re-request.
- gnt, gcd_start and gcd_abort are mutually exclusive in time, and each is at most one cycle wide.

Test Plan:
- Single job: req=0001, A=12, B=18, core done after 5 BUSY cycles with result 6 -> gnt=0001 one cycle, one gcd_start, then rsp_valid with id=0, result=6, err=0.
- Round-robin: req=1111 held, ready=1, each slot re-requests after its grant -> grant order 0,1,2,3,0; no slot granted twice before all others are served.
- Zero bypass: slot 2 with A=0, B=35 -> rsp result=35, id=2, and no gcd_start. A=0, B=0 -> result=0.
- Backpressure: rsp_ready=0 for 10 cycles after valid -> rsp_valid and payload stable throughout, no new gnt while held, IDLE entered after ready.
- Timeout: TIMEOUT=16, core never asserts done -> gcd_abort pulse at BUSY cycle 15, then rsp_err=1 and result=0; the next job starts normally.
- Async reset asserted in BUSY -> all outputs 0 immediately, pointer 0. After release, req=0010 gets gnt=0010.
